// File: rtl/adc_byte_packer_if.sv
// Byte stream from the packer toward the SPI slave sink.
// Avalon-ST, ready latency 0.
interface adc_byte_packer_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/adc_byte_packer.sv
// Buffers ADC samples and emits framed bytes: A5, seq, big-endian payload.
// Optional trailing XOR checksum byte: define ADC_PACK_CHECKSUM_EN.
module adc_byte_packer #(
  parameter int SAMPLE_W   = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 8
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic                        enable,
  input  logic                        adc_valid,
  input  logic [SAMPLE_W-1:0]         adc_data,
  adc_byte_packer_if.master           st,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    HI,
`ifdef ADC_PACK_CHECKSUM_EN
    LO,
    CSUM
`else
    LO
`endif
  } state_t;

  state_t state, nxt;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wp, rp;
  logic [SAMPLE_W-1:0] head;
  logic [7:0]          seq, cnt, byte_o;
  logic                xfer, pop, wr, drop, full, last, vld;
`ifdef ADC_PACK_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  assign head = mem[rp];
  assign full = fifo_level == LW'(FIFO_DEPTH);
  assign last = cnt == 8'(FRAME_LEN - 1);
  assign xfer = vld && st.ready;
  assign pop  = (state == LO) && xfer;
  assign wr   = adc_valid && enable && (!full || pop);
  assign drop = adc_valid && enable && !wr;

  assign st.valid = vld;
  assign st.data  = byte_o;

  always_comb begin
    nxt    = state;
    vld    = 1'b0;
    byte_o = 8'h00;
    unique case (state)
      IDLE: begin
        if (enable && fifo_level >= LW'(FRAME_LEN))
          nxt = HDR;
      end
      HDR: begin
        vld    = 1'b1;
        byte_o = 8'hA5;
        if (xfer) nxt = SEQ;
      end
      SEQ: begin
        vld    = 1'b1;
        byte_o = seq;
        if (xfer) nxt = HI;
      end
      HI: begin
        vld    = 1'b1;
        byte_o = 8'(head >> 8);
        if (xfer) nxt = LO;
      end
      LO: begin
        vld    = 1'b1;
        byte_o = head[7:0];
        if (xfer) begin
`ifdef ADC_PACK_CHECKSUM_EN
          nxt = last ? CSUM : HI;
`else
          nxt = last ? IDLE : HI;
`endif
        end
      end
`ifdef ADC_PACK_CHECKSUM_EN
      CSUM: begin
        vld    = 1'b1;
        byte_o = csum;
        if (xfer) nxt = IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk_clk) begin
    if (wr) mem[wp] <= adc_data;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      seq        <= 8'h00;
      cnt        <= 8'h00;
    end else begin
      state <= nxt;
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (wr && !pop)
        fifo_level <= fifo_level + LW'(1);
      else if (pop && !wr)
        fifo_level <= fifo_level - LW'(1);
      overflow <= drop | (overflow & ~clr_ovf);
      if (pop) cnt <= last ? 8'h00 : cnt + 8'h01;
`ifdef ADC_PACK_CHECKSUM_EN
      if (state == CSUM && xfer) seq <= seq + 8'h01;
`else
      if (pop && last) seq <= seq + 8'h01;
`endif
    end
  end

`ifdef ADC_PACK_CHECKSUM_EN
  // Covers seq and payload; the header is excluded.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      csum <= 8'h00;
    else if (state == IDLE && nxt == HDR)
      csum <= 8'h00;
    else if (xfer && (state == SEQ || state == HI || state == LO))
      csum <= csum ^ byte_o;
  end
`endif
endmodule
